// File: rtl/frame_window_sched.sv
// frame_window_sched: per-frame load/start/filter/done sequencer owning the shared frame-BRAM port
module frame_window_sched #(
   parameter int DATA_W      = 24,
   parameter int ADDR_W      = 17,
   parameter int WIDTH       = 480,
   parameter int HEIGHT      = 272,
   parameter int DEPTH       = WIDTH * HEIGHT,
   parameter int START_HOLD  = 4,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic              iClk,
   input  logic              iRst,
   input  logic              iLoadReq,
   input  logic              iRunReq,
   input  logic              iErrClr,
   input  logic              iWrEn,
   input  logic [ADDR_W-1:0] iWrAddr,
   input  logic [DATA_W-1:0] iWrData,
   input  logic              iWinCs,
   input  logic [ADDR_W-1:0] iWinAddr,
   input  logic              iWinValid,
   output logic              oWinStart,
   output logic              oBramCs,
   output logic              oBramWe,
   output logic [ADDR_W-1:0] oBramAddr,
   output logic [DATA_W-1:0] oBramWdata,
   output logic              oLoadBusy,
   output logic              oFrameDone,
   output logic [19:0]       oValidCnt,
   output logic              oErr,
   output logic [2:0]        oState
);
   localparam int HW = $clog2(START_HOLD + 1);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [ADDR_W:0] DEPTH_W   = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W:0] LOAD_LAST = (ADDR_W + 1)'(DEPTH - 1);
   localparam logic [HW-1:0]   HOLD_LAST = HW'(START_HOLD - 1);
   localparam logic [TW-1:0]   TMO_LAST  = TW'(TIMEOUT_CYC - 1);

   typedef enum logic [2:0] {IDLE = 3'd0, LOAD = 3'd1, START = 3'd2, FILTER = 3'd3, DONE = 3'd4} state_t;

   state_t          state;
   logic [ADDR_W:0] load_cnt;
   logic [HW-1:0]   hold_cnt;
   logic [TW-1:0]   tmo_cnt;
   logic [19:0]     valid_cnt;
   logic            seen, valid_d, win_start, frame_done, err;
   logic            wr_ok, timeout, err_set;

   assign wr_ok   = (state == LOAD) && iWrEn && ({1'b0, iWrAddr} < DEPTH_W);
   assign timeout = (state == FILTER) && !seen && (tmo_cnt == TMO_LAST);
   assign err_set = (iWrEn && !wr_ok) || ((iLoadReq || iRunReq) && state != IDLE) || timeout;

   always_ff @(posedge iClk or negedge iRst) begin
      if (!iRst) begin
         state      <= IDLE;
         load_cnt   <= '0;
         hold_cnt   <= '0;
         tmo_cnt    <= '0;
         valid_cnt  <= '0;
         seen       <= 1'b0;
         valid_d    <= 1'b0;
         win_start  <= 1'b0;
         frame_done <= 1'b0;
         err        <= 1'b0;
      end else begin
         err        <= err_set || (err && !iErrClr);
         valid_d    <= iWinValid;
         frame_done <= 1'b0;
         case (state)
            IDLE:
               if (iLoadReq) begin
                  state    <= LOAD;
                  load_cnt <= '0;
               end else if (iRunReq) begin
                  state     <= START;
                  hold_cnt  <= '0;
                  valid_cnt <= '0;
                  win_start <= 1'b1;
               end
            LOAD:
               if (wr_ok) begin
                  load_cnt <= load_cnt + 1'b1;
                  if (load_cnt == LOAD_LAST) begin
                     state     <= START;
                     hold_cnt  <= '0;
                     valid_cnt <= '0;
                     win_start <= 1'b1;
                  end
               end
            START:
               if (hold_cnt == HOLD_LAST) begin
                  state     <= FILTER;
                  win_start <= 1'b0;
                  seen      <= 1'b0;
                  tmo_cnt   <= '0;
                  // valid already high on entry still counts as a rising edge
                  valid_d   <= 1'b0;
               end else
                  hold_cnt <= hold_cnt + 1'b1;
            FILTER: begin
               if (iWinValid && valid_cnt != '1) valid_cnt <= valid_cnt + 1'b1;
               if (iWinValid && !valid_d) seen <= 1'b1;
               if (!seen) tmo_cnt <= tmo_cnt + 1'b1;
               if ((seen && valid_d && !iWinValid) || timeout) begin
                  state      <= DONE;
                  frame_done <= 1'b1;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign oBramCs    = wr_ok || (state == FILTER && iWinCs);
   assign oBramWe    = wr_ok;
   assign oBramAddr  = state == LOAD ? iWrAddr : state == FILTER ? iWinAddr : '0;
   assign oBramWdata = state == LOAD ? iWrData : '0;
   assign oWinStart  = win_start;
   assign oFrameDone = frame_done;
   assign oValidCnt  = valid_cnt;
   assign oErr       = err;
   assign oLoadBusy  = state == LOAD;
   assign oState     = state;
endmodule

// File: tb/tb_frame_window_sched.sv
// tb_frame_window_sched: directed checks of the frame scheduler on a reduced 16x4 frame
module tb_frame_window_sched;
  localparam int AW = 7, DW = 24, FW = 16, FH = 4, DEPTH = FW * FH, ROW_END = 2;
  logic          clk = 1'b0, rst = 1'b0;
  logic          load_req = 1'b0, run_req = 1'b0, err_clr = 1'b0;
  logic          wr_en = 1'b0, win_cs = 1'b0, win_valid = 1'b0;
  logic [AW-1:0] wr_addr = '0, win_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          win_start, bram_cs, bram_we, load_busy, frame_done, err;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_wdata;
  logic [19:0]   valid_cnt;
  logic [2:0]    state;
  int            total = 0, bad = 0;
  frame_window_sched #(.DATA_W(DW), .ADDR_W(AW), .WIDTH(FW), .HEIGHT(FH), .DEPTH(DEPTH),
                       .START_HOLD(4), .TIMEOUT_CYC(1024)) dut (
    .iClk(clk), .iRst(rst), .iLoadReq(load_req), .iRunReq(run_req), .iErrClr(err_clr),
    .iWrEn(wr_en), .iWrAddr(wr_addr), .iWrData(wr_data), .iWinCs(win_cs), .iWinAddr(win_addr),
    .iWinValid(win_valid), .oWinStart(win_start), .oBramCs(bram_cs), .oBramWe(bram_we),
    .oBramAddr(bram_addr), .oBramWdata(bram_wdata), .oLoadBusy(load_busy), .oFrameDone(frame_done),
    .oValidCnt(valid_cnt), .oErr(err), .oState(state));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic ok);
    total++;
    if (ok !== 1'b1) begin
      bad++;
      $error("FAIL %s", tag);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic load_frame(input int base, input int n);
    for (int a = base; a < base + n; a++) begin
      wr_en = 1'b1; wr_addr = AW'(a); wr_data = DW'(a * 3 + 1);
      #1;
      chk("load_busy", load_busy === 1'b1);
      chk("load_cs", bram_cs === 1'b1);
      chk("load_we", bram_we === 1'b1);
      chk("load_addr", bram_addr === AW'(a));
      chk("load_wdata", bram_wdata === DW'(a * 3 + 1));
      tick;
    end
    wr_en = 1'b0;
  endtask
  task automatic start_phase;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("start_state", state === 3'd2);
      chk("start_pulse", win_start === 1'b1);
      chk("start_busy", load_busy === 1'b0);
      chk("start_cnt_clr", valid_cnt === 20'd0);
      tick;
    end
    #1;
    chk("filter_state", state === 3'd3);
    chk("start_low", win_start === 1'b0);
  endtask
  task automatic filter_run(input int n_valid);
    for (int i = 0; i < 3; i++) begin
      win_cs = i[0]; win_addr = AW'(100 + i);
      #1;
      chk("filt_cs", bram_cs === i[0]);
      chk("filt_addr", bram_addr === AW'(100 + i));
      tick;
    end
    for (int i = 0; i < n_valid; i++) begin
      win_valid = 1'b1; win_cs = 1'b1; win_addr = AW'(i % 128); wr_data = 24'hABCDEF;
      #1;
      chk("filt_state", state === 3'd3);
      chk("filt_cs_v", bram_cs === 1'b1);
      chk("filt_addr_v", bram_addr === AW'(i % 128));
      chk("filt_we", bram_we === 1'b0);
      chk("filt_wdata", bram_wdata === DW'(0));
      tick;
    end
    win_valid = 1'b0; win_cs = 1'b0;
    #1;
    chk("fall_state", state === 3'd3);
    chk("fall_no_done", frame_done === 1'b0);
    tick;
    chk("done_state", state === 3'd4);
    chk("done_pulse", frame_done === 1'b1);
    chk("valid_cnt", valid_cnt === 20'(n_valid));
    tick;
    chk("post_idle", state === 3'd0);
    chk("done_one_cyc", frame_done === 1'b0);
  endtask
  initial begin
    tick; tick;
    chk("rst_state", state === 3'd0);
    chk("rst_start", win_start === 1'b0);
    chk("rst_done", frame_done === 1'b0);
    chk("rst_err", err === 1'b0);
    chk("rst_cnt", valid_cnt === 20'd0);
    chk("rst_cs", bram_cs === 1'b0);
    rst = 1'b1;
    tick;
    win_cs = 1'b1; win_addr = 7'd5;
    #1;
    chk("idle_cs_ignored", bram_cs === 1'b0);
    chk("idle_addr", bram_addr === AW'(0));
    win_cs = 1'b0; win_addr = '0;
    load_req = 1'b1;
    tick;
    load_req = 1'b0;
    chk("load_state", state === 3'd1);
    chk("load_busy0", load_busy === 1'b1);
    wr_addr = 7'd9;
    #1;
    chk("gap_cs", bram_cs === 1'b0);
    chk("gap_we", bram_we === 1'b0);
    tick;
    load_frame(0, DEPTH);
    start_phase();
    filter_run(FH * (FW + ROW_END));
    chk("frame1_err", err === 1'b0);
    run_req = 1'b1;
    tick;
    run_req = 1'b0;
    chk("run_no_load", load_busy === 1'b0);
    start_phase();
    for (int i = 0; i < 1023; i++) tick;
    chk("tmo_pre_state", state === 3'd3);
    chk("tmo_pre_err", err === 1'b0);
    tick;
    chk("tmo_state", state === 3'd4);
    chk("tmo_err", err === 1'b1);
    chk("tmo_done", frame_done === 1'b1);
    tick;
    chk("tmo_idle", state === 3'd0);
    chk("err_sticky", err === 1'b1);
    err_clr = 1'b1;
    tick;
    err_clr = 1'b0;
    chk("err_clr", err === 1'b0);
    err_clr = 1'b1; wr_en = 1'b1;
    #1;
    chk("idle_wr_blocked", bram_cs === 1'b0);
    tick;
    err_clr = 1'b0; wr_en = 1'b0;
    chk("set_wins", err === 1'b1);
    err_clr = 1'b1;
    tick;
    err_clr = 1'b0;
    load_req = 1'b1; run_req = 1'b1;
    tick;
    load_req = 1'b0; run_req = 1'b0;
    chk("both_load", state === 3'd1);
    chk("both_err", err === 1'b0);
    wr_en = 1'b1; wr_addr = AW'(DEPTH);
    #1;
    chk("oob_cs", bram_cs === 1'b0);
    chk("oob_we", bram_we === 1'b0);
    tick;
    wr_en = 1'b0;
    chk("oob_err", err === 1'b1);
    chk("oob_state", state === 3'd1);
    err_clr = 1'b1;
    tick;
    err_clr = 1'b0;
    load_frame(0, DEPTH);
    start_phase();
    load_req = 1'b1;
    tick;
    load_req = 1'b0;
    chk("filt_req_state", state === 3'd3);
    chk("filt_req_err", err === 1'b1);
    filter_run(5);
    err_clr = 1'b1;
    tick;
    err_clr = 1'b0;
    load_req = 1'b1;
    tick;
    load_req = 1'b0;
    load_frame(0, 20);
    wr_en = 1'b1; wr_addr = 7'd20;
    rst = 1'b0;
    #1;
    chk("mid_rst_state", state === 3'd0);
    chk("mid_rst_cs", bram_cs === 1'b0);
    chk("mid_rst_addr", bram_addr === AW'(0));
    chk("mid_rst_busy", load_busy === 1'b0);
    wr_en = 1'b0;
    tick;
    rst = 1'b1;
    tick;
    load_req = 1'b1;
    tick;
    load_req = 1'b0;
    load_frame(0, DEPTH - 1);
    chk("reload_still_load", state === 3'd1);
    load_frame(DEPTH - 1, 1);
    chk("reload_start", state === 3'd2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/frame_window_sched.md
Name: frame_window_sched

Overview:
- Frame-level scheduler that owns the single frame-BRAM port shared by the pixel loader (write side) and the 3x3 RGB888 window generator (read side).
- Sequences each frame as: load the frame, start the window generator, wait for the filtering pass to finish, signal done.
- Sits between the loader, the window block and the frame BRAM; top-level control sees only request pulses, done and error.

Parameters:
DATA_W, 24, pixel width (RGB888)
ADDR_W, 17, BRAM address width
WIDTH, 480, frame width in pixels
HEIGHT, 272, frame height in pixels
DEPTH, 130560, frame size in words (WIDTH*HEIGHT)
START_HOLD, 4, cycles oWinStart is held high; must be >=3 to cover the window block's 2-FF start synchroniser
TIMEOUT_CYC, 1024, max cycles in FILTER before the first iWinValid

Ports:
iClk  in  1  clock
iRst  in  1  asynchronous active-low reset
iLoadReq  in  1  pulse: load a new frame, then filter it
iRunReq  in  1  pulse: filter the frame already in BRAM (no load)
iErrClr  in  1  pulse: clear oErr
iWrEn  in  1  loader write strobe
iWrAddr  in  ADDR_W  loader write address
iWrData  in  DATA_W  loader write data
iWinCs  in  1  window block BRAM chip select
iWinAddr  in  ADDR_W  window block BRAM address
iWinValid  in  1  window block output valid
oWinStart  out  1  to window block iStart
oBramCs  out  1  BRAM chip select
oBramWe  out  1  BRAM write enable
oBramAddr  out  ADDR_W  BRAM address
oBramWdata  out  DATA_W  BRAM write data
oLoadBusy  out  1  high while in LOAD
oFrameDone  out  1  one-cycle done pulse
oValidCnt  out  20  iWinValid cycles counted in the last FILTER pass; saturates at 2^20-1
oErr  out  1  sticky error flag
oState  out  3  current state code

Behaviour:
- Reset: the asynchronous active-low iRst forces IDLE, zeroes all counters and drives every output to 0. This applies mid-operation as well; there is no resume.
- States: IDLE=0, LOAD=1, START=2, FILTER=3, DONE=4. Codes 5-7 go to IDLE on the next cycle.
- IDLE:
  - iLoadReq -> LOAD.
  - iRunReq -> START.
  - Both requests in the same cycle -> LOAD; the run request is dropped.
- LOAD:
  - A write is accepted when iWrEn=1 and iWrAddr<DEPTH. Accepted writes increment the load counter.
  - iWrEn=1 with iWrAddr>=DEPTH: the write is blocked (oBramCs=0) and oErr is set.
  - The accepted write that takes the counter to DEPTH causes the move to START on the next cycle.
- START:
  - oWinStart=1 for exactly START_HOLD cycles, then -> FILTER.
  - oWinStart is registered and is 0 in every other state.
- FILTER:
  - iWinValid rising latches "seen". Each high cycle increments oValidCnt; the counter clears on entry to START.
  - A falling edge of iWinValid after "seen" -> DONE.
  - If "seen" is still low after TIMEOUT_CYC cycles: set oErr, -> DONE.
- DONE: oFrameDone=1 for one cycle, then -> IDLE.
- Port mux is combinational, selected by the registered state, so the window block's own read latency is unchanged:
  - LOAD: oBramCs=iWrEn and address-ok, oBramWe=oBramCs, oBramAddr=iWrAddr, oBramWdata=iWrData.
  - FILTER: oBramCs=iWinCs, oBramWe=0, oBramAddr=iWinAddr, oBramWdata=0.
  - All other states: all BRAM outputs 0.
  - iWinCs is ignored outside FILTER.
- Writes outside LOAD are blocked and set oErr.
- iLoadReq or iRunReq outside IDLE is ignored and sets oErr.
- oErr stays high until iErrClr. If iErrClr and a new error occur in the same cycle, the set wins.
- oLoadBusy = (state==LOAD).

Test Plan:
- Reset, then iLoadReq, then 130560 sequential writes: oLoadBusy=1 throughout, oBramWe mirrors iWrEn, START is entered the cycle after the write to address 130559, oWinStart is high for exactly 4 cycles.
- Window model with valid for 272 rows plus ROW_END cycles: in FILTER the BRAM outputs track iWinAddr/iWinCs with 0 latency, oBramWe=0; oFrameDone pulses one cycle after valid falls; oValidCnt equals the modelled count.
- iRunReq in IDLE: no LOAD, oWinStart pulses 4 cycles; iWinValid never rises -> after 1024 cycles oErr=1 and oFrameDone pulses; iErrClr -> oErr=0.
- iLoadReq and iRunReq in the same cycle -> LOAD. A write to address 130560 is blocked and sets oErr. iLoadReq during FILTER is ignored, oErr=1.
- Assert iRst mid-LOAD (at write 5000): all outputs 0 at once, IDLE; a new iLoadReq needs a full 130560 writes before START.
